// File: rtl/digit_pkg.sv
// Shared definitions for the digit slicer: default widths and measurement FSM states.
package digit_pkg;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/digit_slicer_if.sv
// Sample/threshold inputs and measurement outputs of the digit slicer.
interface digit_slicer_if #(
    parameter int DW = 8,
    parameter int CW = 32
);
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic [DW-1:0] mid;
    logic [DW-1:0] diff;
    logic          dig_out;
    logic          rise;
    logic          fall;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          no_signal;

    modport master (
        output sample_valid, sample, mid, diff,
        input  dig_out, rise, fall, period, high_time, meas_valid, no_signal
    );

    modport slave (
        input  sample_valid, sample, mid, diff,
        output dig_out, rise, fall, period, high_time, meas_valid, no_signal
    );
endinterface

// File: rtl/digit_slicer_hyst.sv
// Hysteresis slicer: saturating thresholds around mid, registered level and edge pulses.
module hyst_slicer #(
    parameter int DW        = 8,
    parameter int HYS_SHIFT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] mid,
    input  logic [DW-1:0] diff,
    output logic          dig_out,
    output logic          rise,
    output logic          fall
);

    logic [DW:0]   h_ext;
    logic [DW:0]   hi_sum;
    logic [DW:0]   lo_sub;
    logic [DW-1:0] thr_hi_next;
    logic [DW-1:0] thr_lo_next;
    logic [DW-1:0] thr_hi;
    logic [DW-1:0] thr_lo;

    // One extra bit catches overflow of mid+h and borrow of mid-h for saturation.
    always_comb begin
        h_ext       = {1'b0, diff >> HYS_SHIFT};
        hi_sum      = {1'b0, mid} + h_ext;
        lo_sub      = {1'b0, mid} - h_ext;
        thr_hi_next = hi_sum[DW] ? '1 : hi_sum[DW-1:0];
        thr_lo_next = lo_sub[DW] ? '0 : lo_sub[DW-1:0];
    end

    // Thresholds follow the tracker every cycle; they carry no state worth resetting.
    always_ff @(posedge clk) begin
        thr_hi <= thr_hi_next;
        thr_lo <= thr_lo_next;
    end

    // Level only moves on a qualified sample strictly beyond the opposite threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_out <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample_valid) begin
                if (!dig_out && (sample > thr_hi)) begin
                    dig_out <= 1'b1;
                    rise    <= 1'b1;
                end else if (dig_out && (sample < thr_lo)) begin
                    dig_out <= 1'b0;
                    fall    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/digit_slicer.sv
// Digit slicer top: hysteresis slicer plus period/high-time measurement and loss-of-signal.
module digit_slicer
    import digit_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int CW        = CW_DEF,
    parameter int HYS_SHIFT = 2,
    parameter int TIMEOUT   = 10_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    digit_slicer_if.slave  bus
);

    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    logic          dig_out;
    logic          rise;
    logic          fall;
    logic [CW-1:0] pcnt;
    logic [CW-1:0] hcnt;
    logic          fall_seen;
    state_t        state;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          no_signal;

    hyst_slicer #(
        .DW        (DW),
        .HYS_SHIFT (HYS_SHIFT)
    ) u_slicer (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (bus.sample_valid),
        .sample       (bus.sample),
        .mid          (bus.mid),
        .diff         (bus.diff),
        .dig_out      (dig_out),
        .rise         (rise),
        .fall         (fall)
    );

    // Cycle counter restarted by each rise, parked at TIMEOUT so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (rise) begin
            pcnt <= CW'(1);
        end else if (pcnt != TMO) begin
            pcnt <= pcnt + CW'(1);
        end
    end

    // Snapshot of the rise-to-fall distance, consumed at the next rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt <= '0;
        end else if (fall) begin
            hcnt <= pcnt;
        end
    end

    // Measurement FSM: a rise only publishes results when a fall was seen since the last rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fall_seen  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            if (fall) begin
                fall_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= ARMED;
                        fall_seen <= 1'b0;
                    end
                end
                ARMED, RUN: begin
                    if (rise) begin
                        fall_seen <= 1'b0;
                        if (fall_seen) begin
                            period     <= pcnt;
                            high_time  <= hcnt;
                            meas_valid <= 1'b1;
                            no_signal  <= 1'b0;
                            state      <= RUN;
                        end
                    end else if (pcnt == TMO) begin
                        state     <= IDLE;
                        no_signal <= 1'b1;
                        period    <= '0;
                        high_time <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dig_out    = dig_out;
    assign bus.rise       = rise;
    assign bus.fall       = fall;
    assign bus.period     = period;
    assign bus.high_time  = high_time;
    assign bus.meas_valid = meas_valid;
    assign bus.no_signal  = no_signal;

endmodule

// File: tb/tb_digit_slicer.sv
// Directed testbench for digit_slicer with hand-computed expectations.
module tb_digit_slicer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    digit_slicer_if #(.DW(8), .CW(32)) bus ();

    digit_slicer #(
        .DW        (8),
        .CW        (32),
        .HYS_SHIFT (2),
        .TIMEOUT   (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [7:0] s);
        bus.sample_valid = v;
        bus.sample       = s;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic setThresholds(input logic [7:0] m, input logic [7:0] d);
        bus.mid  = m;
        bus.diff = d;
        applyStimulus(1'b0, 8'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".dig_out"}, 32'(bus.dig_out), 32'd0);
        checkOutput({tag, ".rise"}, 32'(bus.rise), 32'd0);
        checkOutput({tag, ".fall"}, 32'(bus.fall), 32'd0);
        checkOutput({tag, ".period"}, bus.period, 32'd0);
        checkOutput({tag, ".high_time"}, bus.high_time, 32'd0);
        checkOutput({tag, ".meas_valid"}, 32'(bus.meas_valid), 32'd0);
        checkOutput({tag, ".no_signal"}, 32'(bus.no_signal), 32'd1);
    endtask

    // 30 samples high then 70 low; rise appears after sample 0, fall after sample 30.
    task automatic squarePeriod(input bit expect_meas);
        for (int j = 0; j < 100; j++) begin
            applyStimulus(1'b1, (j < 30) ? 8'd200 : 8'd50);
            checkOutput("sq.rise", 32'(bus.rise), 32'(j == 0));
            checkOutput("sq.fall", 32'(bus.fall), 32'(j == 30));
            checkOutput("sq.meas_valid", 32'(bus.meas_valid), 32'(expect_meas && (j == 1)));
            if (expect_meas && (j == 1)) begin
                checkOutput("sq.period", bus.period, 32'd100);
                checkOutput("sq.high_time", bus.high_time, 32'd30);
                checkOutput("sq.no_signal", 32'(bus.no_signal), 32'd0);
            end
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample       = 8'd200;
        bus.mid          = 8'd128;
        bus.diff         = 8'd100;

        $display("[TB] reset hold");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd200);
        checkResetState("reset");
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd50);

        $display("[TB] hysteresis mid=128 diff=100");
        setThresholds(8'd128, 8'd100);
        applyStimulus(1'b0, 8'd255);
        checkOutput("hys.invalid_hold", 32'(bus.dig_out), 32'd0);
        applyStimulus(1'b1, 8'd150);
        checkOutput("hys.150", 32'(bus.dig_out), 32'd0);
        applyStimulus(1'b1, 8'd153);
        checkOutput("hys.153_equal", 32'(bus.dig_out), 32'd0);
        applyStimulus(1'b1, 8'd154);
        checkOutput("hys.154", 32'(bus.dig_out), 32'd1);
        checkOutput("hys.rise", 32'(bus.rise), 32'd1);
        applyStimulus(1'b1, 8'd110);
        checkOutput("hys.110", 32'(bus.dig_out), 32'd1);
        checkOutput("hys.rise_pulse_end", 32'(bus.rise), 32'd0);
        applyStimulus(1'b1, 8'd103);
        checkOutput("hys.103_equal", 32'(bus.dig_out), 32'd1);
        checkOutput("hys.no_fall", 32'(bus.fall), 32'd0);
        applyStimulus(1'b1, 8'd102);
        checkOutput("hys.102", 32'(bus.dig_out), 32'd0);
        checkOutput("hys.fall", 32'(bus.fall), 32'd1);
        applyStimulus(1'b0, 8'd0);
        checkOutput("hys.fall_pulse_end", 32'(bus.fall), 32'd0);

        $display("[TB] square wave");
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'd50);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd50);
        checkOutput("sq.no_signal_before", 32'(bus.no_signal), 32'd1);
        squarePeriod(1'b0);
        checkOutput("sq.no_signal_armed", 32'(bus.no_signal), 32'd1);
        squarePeriod(1'b1);
        squarePeriod(1'b1);
        squarePeriod(1'b1);

        $display("[TB] reset between rise and fall");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'd200);
        checkOutput("rr.high_before", 32'(bus.dig_out), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'd200);
        checkResetState("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, 8'd50);
        squarePeriod(1'b0);
        squarePeriod(1'b1);

        $display("[TB] threshold saturation");
        setThresholds(8'd250, 8'd200);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'd255);
            checkOutput("sat.hi_255", 32'(bus.dig_out), 32'd0);
        end
        setThresholds(8'd10, 8'd200);
        applyStimulus(1'b1, 8'd61);
        checkOutput("sat.set_61", 32'(bus.dig_out), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'd0);
            checkOutput("sat.lo_0", 32'(bus.dig_out), 32'd1);
        end
        setThresholds(8'd128, 8'd100);
        applyStimulus(1'b1, 8'd50);
        checkOutput("sat.clear_50", 32'(bus.dig_out), 32'd0);

        $display("[TB] timeout");
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'd50);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd50);
        squarePeriod(1'b0);
        squarePeriod(1'b1);
        for (int m = 100; m <= 1001; m++) begin
            applyStimulus(1'b1, 8'd50);
            if (m == 1000) begin
                checkOutput("to.before", 32'(bus.no_signal), 32'd0);
                checkOutput("to.period_held", bus.period, 32'd100);
            end
        end
        checkOutput("to.no_signal", 32'(bus.no_signal), 32'd1);
        checkOutput("to.period", bus.period, 32'd0);
        checkOutput("to.high_time", bus.high_time, 32'd0);
        squarePeriod(1'b0);
        checkOutput("to.rearm_no_signal", 32'(bus.no_signal), 32'd1);
        squarePeriod(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
